// File: rtl/ce_divider_bank.sv
// Clock-enable generator bank: CPU p/n enable pair with a runtime period,
// NUM_CH integer-divided channel enables and one fractional (NCO) enable.
module ce_divider_bank #(
    parameter int unsigned NUM_CH          = 3,
    parameter int unsigned DIV_W           = 8,
    parameter int unsigned ACC_W           = 16,
    parameter int unsigned CPU_DIV_DEFAULT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DIV_W-1:0]         cpu_div,
    input  logic                     cpu_stall,
    input  logic [NUM_CH*DIV_W-1:0]  ch_div,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [ACC_W-1:0]         frac_inc,
    input  logic                     resync,
    output logic                     cpu_ce_p,
    output logic                     cpu_ce_n,
    output logic [NUM_CH-1:0]        ch_ce,
    output logic                     frac_ce,
    output logic [DIV_W-1:0]         cpu_div_active
);

    localparam logic [DIV_W-1:0] CPU_DIV_RST = DIV_W'(CPU_DIV_DEFAULT);
    localparam logic [DIV_W-1:0] DIV_MIN     = DIV_W'(2);

    logic [DIV_W-1:0] cpu_cnt;
    logic [DIV_W-1:0] cpu_div_san;
    logic [DIV_W-1:0] cpu_half;
    logic             cpu_wrap;
    logic [DIV_W-1:0] ch_cnt [NUM_CH];
    logic [DIV_W-1:0] ch_lat [NUM_CH];
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;

    // Period sanitising (even, >=2), CPU decode terms and NCO sum
    always_comb begin
        cpu_div_san = {cpu_div[DIV_W-1:1], 1'b0};
        if (cpu_div_san < DIV_MIN) begin
            cpu_div_san = DIV_MIN;
        end
        cpu_half = cpu_div_active >> 1;
        cpu_wrap = (cpu_cnt == (cpu_div_active - DIV_W'(1)));
        acc_sum  = {1'b0, acc} + {1'b0, frac_inc};
    end

    // CPU counter, period update at the wrap, and p/n enables
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_cnt        <= '0;
            cpu_ce_p       <= 1'b0;
            cpu_ce_n       <= 1'b0;
            cpu_div_active <= CPU_DIV_RST;
        end else if (resync) begin
            cpu_cnt  <= '0;
            cpu_ce_p <= 1'b0;
            cpu_ce_n <= 1'b0;
        end else begin
            cpu_ce_p <= (cpu_cnt == '0) && !cpu_stall;
            cpu_ce_n <= (cpu_cnt == cpu_half) && !cpu_stall;
            if (!cpu_stall) begin
                if (cpu_wrap) begin
                    cpu_cnt        <= '0;
                    cpu_div_active <= cpu_div_san;
                end else begin
                    cpu_cnt <= cpu_cnt + DIV_W'(1);
                end
            end
        end
    end

    // Integer channels: divisor latched on wrap, counter parked while disabled
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                ch_cnt[i] <= '0;
                ch_lat[i] <= ch_div[i*DIV_W +: DIV_W];
                ch_ce[i]  <= 1'b0;
            end else if (resync) begin
                ch_cnt[i] <= '0;
                ch_ce[i]  <= 1'b0;
            end else if (!ch_en[i]) begin
                ch_cnt[i] <= '0;
                ch_ce[i]  <= 1'b0;
            end else begin
                ch_ce[i] <= (ch_cnt[i] == '0);
                if (ch_cnt[i] == ch_lat[i]) begin
                    ch_cnt[i] <= '0;
                    ch_lat[i] <= ch_div[i*DIV_W +: DIV_W];
                end else begin
                    ch_cnt[i] <= ch_cnt[i] + DIV_W'(1);
                end
            end
        end
    end

    // Fractional NCO: accumulator carry becomes the enable
    always_ff @(posedge clk) begin
        if (reset || resync) begin
            acc     <= '0;
            frac_ce <= 1'b0;
        end else begin
            acc     <= acc_sum[ACC_W-1:0];
            frac_ce <= acc_sum[ACC_W];
        end
    end

endmodule

// File: tb/tb_ce_divider_bank.sv
// Directed bench for ce_divider_bank; outputs sampled 1 ns after each rising edge.
module tb_ce_divider_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cpu_div;
    logic        cpu_stall;
    logic [23:0] ch_div;
    logic [2:0]  ch_en;
    logic [15:0] frac_inc;
    logic        resync;
    logic        cpu_ce_p;
    logic        cpu_ce_n;
    logic [2:0]  ch_ce;
    logic        frac_ce;
    logic [7:0]  cpu_div_active;

    int total = 0;
    int bad   = 0;

    ce_divider_bank dut (
        .clk(clk), .reset(reset), .cpu_div(cpu_div), .cpu_stall(cpu_stall),
        .ch_div(ch_div), .ch_en(ch_en), .frac_inc(frac_inc), .resync(resync),
        .cpu_ce_p(cpu_ce_p), .cpu_ce_n(cpu_ce_n), .ch_ce(ch_ce),
        .frac_ce(frac_ce), .cpu_div_active(cpu_div_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle resync; all enables must be low in the resync cycle
    task automatic do_resync();
        resync = 1'b1;
        tick();
        chk("resync_p", 32'(cpu_ce_p), 32'd0);
        chk("resync_n", 32'(cpu_ce_n), 32'd0);
        chk("resync_ch", 32'(ch_ce), 32'd0);
        chk("resync_frac", 32'(frac_ce), 32'd0);
        resync = 1'b0;
    endtask

    // Bounded wait for cpu_div_active to reach a value
    task automatic wait_active(input logic [7:0] want, input string tag);
        for (int k = 0; k < 40; k++) begin
            if (cpu_div_active == want) break;
            tick();
        end
        chk(tag, 32'(cpu_div_active), 32'(want));
    endtask

    // p and n must never coincide
    always @(negedge clk) begin
        if (reset === 1'b0) chk("pn_excl", 32'(cpu_ce_p & cpu_ce_n), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_ch;
        reset     = 1'b1;
        cpu_div   = 8'd16;
        cpu_stall = 1'b0;
        ch_div    = {8'd9, 8'd0, 8'd3};
        ch_en     = 3'b000;
        frac_inc  = 16'h0000;
        resync    = 1'b0;
        tick();
        tick();
        chk("rst_p", 32'(cpu_ce_p), 32'd0);
        chk("rst_n", 32'(cpu_ce_n), 32'd0);
        chk("rst_ch", 32'(ch_ce), 32'd0);
        chk("rst_frac", 32'(frac_ce), 32'd0);
        chk("rst_active", 32'(cpu_div_active), 32'd16);

        // 1: period 16, p first cycle after release, n 8 later
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk("t1_p", 32'(cpu_ce_p), 32'(((k - 1) % 16) == 0));
            chk("t1_n", 32'(cpu_ce_n), 32'(((k - 1) % 16) == 8));
            chk("t1_frac", 32'(frac_ce), 32'd0);
        end

        // 2: change to 8 at cpu_cnt=5; current period stays 16
        do_resync();
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (j == 5) cpu_div = 8'd8;
            if (j >= 6) begin
                chk("t2_p", 32'(cpu_ce_p), 32'(j == 17 || (j > 17 && ((j - 17) % 8) == 0)));
                chk("t2_n", 32'(cpu_ce_n), 32'(j == 9 || (j >= 21 && ((j - 21) % 8) == 0)));
            end
            if (j == 15) chk("t2_act_old", 32'(cpu_div_active), 32'd16);
            if (j == 16) chk("t2_act_new", 32'(cpu_div_active), 32'd8);
        end
        cpu_div = 8'd1;
        wait_active(8'd2, "t2_san1");
        cpu_div = 8'd7;
        wait_active(8'd6, "t2_san7");
        cpu_div = 8'd16;
        wait_active(8'd16, "t2_back16");

        // 3: stall 3 clk over cpu_cnt=0
        do_resync();
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (j == 16) cpu_stall = 1'b1;
            if (j == 19) cpu_stall = 1'b0;
            if (j >= 17 && j <= 19) begin
                chk("t3_stall_p", 32'(cpu_ce_p), 32'd0);
                chk("t3_stall_n", 32'(cpu_ce_n), 32'd0);
            end
            if (j >= 20) begin
                chk("t3_p", 32'(cpu_ce_p), 32'(j == 20));
                chk("t3_n", 32'(cpu_ce_n), 32'(j == 28));
            end
        end

        // 4: channels 4/1/10, then gate ch2 mid-count
        ch_en = 3'b111;
        do_resync();
        for (int j = 1; j <= 25; j++) begin
            tick();
            exp_ch = {((j - 1) % 10) == 0, 1'b1, ((j - 1) % 4) == 0};
            chk("t4_ch", 32'(ch_ce), 32'(exp_ch));
        end
        ch_en[2] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("t4_ch2_off", 32'(ch_ce[2]), 32'd0);
        end
        ch_en[2] = 1'b1;
        tick();
        chk("t4_ch2_reen", 32'(ch_ce[2]), 32'd1);
        tick();
        chk("t4_ch2_after", 32'(ch_ce[2]), 32'd0);

        // 5: NCO 1/4 then 3/8
        frac_inc = 16'h4000;
        do_resync();
        for (int j = 1; j <= 16; j++) begin
            tick();
            chk("t5_quarter", 32'(frac_ce), 32'((j % 4) == 0));
        end
        frac_inc = 16'h6000;
        do_resync();
        for (int j = 1; j <= 16; j++) begin
            tick();
            chk("t5_3of8", 32'(frac_ce), 32'((j % 8) == 3 || (j % 8) == 6 || (j % 8) == 0));
        end
        frac_inc = 16'h0000;

        // 6: resync mid-run then first enables one cycle later; reset beats resync
        repeat (7) tick();
        do_resync();
        tick();
        chk("t6_p", 32'(cpu_ce_p), 32'd1);
        chk("t6_ch", 32'(ch_ce), 32'd7);
        chk("t6_act_kept", 32'(cpu_div_active), 32'd16);
        cpu_div = 8'd8;
        wait_active(8'd8, "t6_act8");
        reset  = 1'b1;
        resync = 1'b1;
        tick();
        chk("t6_rst_act", 32'(cpu_div_active), 32'd16);
        chk("t6_rst_p", 32'(cpu_ce_p), 32'd0);
        chk("t6_rst_ch", 32'(ch_ce), 32'd0);
        reset  = 1'b0;
        resync = 1'b0;
        tick();
        chk("t6_post_p", 32'(cpu_ce_p), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
